// File: rtl/spi_slave_regif_if.sv
// Register-bus interface between the SPI slave and a register file.
//   reg_addr  : register address (ADDR_W bits), driven by the SPI slave
//   reg_wdata : write data, driven by the SPI slave
//   reg_we    : one-cycle write strobe
//   reg_re    : one-cycle read strobe
//   reg_rdata : read data, driven by the register file; valid the cycle after reg_re
// Modports: master = SPI slave side, slave = register file side.
interface spi_slave_regif_if #(
  parameter int ADDR_W = 7
) ();
  logic [ADDR_W-1:0] reg_addr;
  logic [15:0]       reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [15:0]       reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave bridging command/data frames onto a simple register bus.
// Frame: command byte (bit7 = 1 read, 0 write; low ADDR_W bits = start address)
// followed by 16-bit words, MSB first. All SPI pins are oversampled by sck_in.
//
// Ports:
//   sck_in     : system clock (only clock, rising edge)
//   rst_n      : asynchronous active-low reset
//   spi_sck    : SPI clock from master (asynchronous)
//   spi_cs_n   : chip select, active low
//   spi_mosi   : master-out data
//   spi_miso   : slave-out data
//   miso_oe    : MISO output enable, high while synchronised CS is low
//   frame_done : one-cycle pulse at CS rise after a complete command byte
//   reg_bus    : register bus (master modport of spi_slave_regif_if)
//
// Optional feature: define SPI_SLAVE_AUTOINC_EN to advance reg_addr by one
// (wrapping) after each completed word; otherwise the address is fixed per frame.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | CS high (or waiting for a fresh CS fall after reset)
// CMD   | shifting in the command byte
// WR    | shifting in write words, reg_we after each 16th bit
// RD    | shifting out read words, reg_re after command and each word
module spi_slave_regif #(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic sck_in,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic miso_oe,
  output logic frame_done,
  spi_slave_regif_if.master reg_bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WR, ST_RD} state_t;

  // Edges are ignored until the synchronisers and the previous-sample flops
  // hold real pin values, so a reset released mid-frame cannot fake a CS fall.
  localparam logic [2:0]        SETTLE_LEN = 3'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [2:0]             settle_q, settle_d;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [14:0]       rx_sh_q, rx_sh_d;
  logic [15:0]       tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [15:0]       reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              rd_load_q, rd_load_d;
  logic              frame_done_q, frame_done_d;

  logic       sck_s, cs_s, mosi_s, edges_en;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0] cmd_byte;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign edges_en = (settle_q == SETTLE_LEN);
  assign sck_rise = edges_en &  sck_s & ~sck_prev_q;
  assign sck_fall = edges_en & ~sck_s &  sck_prev_q;
  assign cs_rise  = edges_en &  cs_s  & ~cs_prev_q;
  assign cs_fall  = edges_en & ~cs_s  &  cs_prev_q;
  assign cmd_byte = {rx_sh_q[6:0], mosi_s};

  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d   = sck_s;
    cs_prev_d    = cs_s;
    settle_d     = edges_en ? settle_q : settle_q + 3'd1;

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sh_d      = rx_sh_q;
    tx_sh_d      = tx_sh_q;
    miso_d       = miso_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    rd_load_d    = reg_re_q;
    frame_done_d = 1'b0;

    if (rd_load_q) tx_sh_d = reg_bus.reg_rdata;

`ifdef SPI_SLAVE_AUTOINC_EN
    // Advance only after the write strobe cycle so addr is stable with reg_we.
    if (reg_we_q) reg_addr_d = reg_addr_q + ADDR_ONE;
`endif

    if (cs_rise) begin
      // CS rise has priority over a coincident 16th sck edge: no strobe.
      frame_done_d = (state_q == ST_WR) || (state_q == ST_RD);
      state_d      = ST_IDLE;
      bit_cnt_d    = 4'd0;
      miso_d       = 1'b0;
      tx_sh_d      = 16'd0;
      rd_load_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 4'd0;
            rx_sh_d   = 15'd0;
            tx_sh_d   = 16'd0;
            miso_d    = 1'b0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_sh_d   = {rx_sh_q[13:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              reg_addr_d = cmd_byte[ADDR_W-1:0];
              if (cmd_byte[7]) begin
                state_d  = ST_RD;
                reg_re_d = 1'b1;
              end else begin
                state_d  = ST_WR;
              end
            end
          end
        end
        ST_WR: begin
          if (sck_rise) begin
            rx_sh_d   = {rx_sh_q[13:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              reg_we_d    = 1'b1;
              reg_wdata_d = {rx_sh_q, mosi_s};
            end
          end
        end
        ST_RD: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              reg_re_d = 1'b1;
`ifdef SPI_SLAVE_AUTOINC_EN
              // Move the address together with reg_re so the strobe sees the next register.
              reg_addr_d = reg_addr_q + ADDR_ONE;
`endif
            end
          end
          if (sck_fall) begin
            miso_d  = tx_sh_q[15];
            tx_sh_d = {tx_sh_q[14:0], 1'b0};
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sck_in or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      settle_q     <= 3'd0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      rx_sh_q      <= 15'd0;
      tx_sh_q      <= 16'd0;
      miso_q       <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= 16'd0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      rd_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_prev_q   <= sck_prev_d;
      cs_prev_q    <= cs_prev_d;
      settle_q     <= settle_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sh_q      <= rx_sh_d;
      tx_sh_q      <= tx_sh_d;
      miso_q       <= miso_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      rd_load_q    <= rd_load_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign spi_miso          = miso_q;
  assign miso_oe           = ~cs_s;
  assign frame_done        = frame_done_q;
  assign reg_bus.reg_addr  = reg_addr_q;
  assign reg_bus.reg_wdata = reg_wdata_q;
  assign reg_bus.reg_we    = reg_we_q;
  assign reg_bus.reg_re    = reg_re_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Scoreboard bench for spi_slave_regif: the frame model pushes expected
// register writes, read strobes, MISO bits and frame_done pulses into queues;
// independent monitors pop and compare as the DUT produces them.
module tb_spi_slave_regif;
  localparam int AW   = 7;
  localparam int HALF = 8;
`ifdef SPI_SLAVE_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic sck_in   = 1'b0;
  logic rst_n    = 1'b0;
  logic spi_sck  = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, miso_oe, frame_done;

  spi_slave_regif_if #(.ADDR_W(AW)) bus ();

  spi_slave_regif #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .sck_in    (sck_in),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .miso_oe   (miso_oe),
    .frame_done(frame_done),
    .reg_bus   (bus)
  );

  always #5 sck_in = ~sck_in;

  int total = 0;
  int bad   = 0;

  logic [15:0] slave_mem [128];
  logic [15:0] model_mem [128];
  logic [15:0] words [4];

  logic [22:0] exp_wr[$];
  logic [6:0]  exp_rd[$];
  bit          exp_fd[$];
  bit          exp_miso[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file stand-in: read data valid the cycle after reg_re.
  always @(posedge sck_in) begin
    if (bus.reg_re) bus.reg_rdata <= slave_mem[bus.reg_addr];
  end

  always @(negedge sck_in) begin
    if (rst_n) begin
      if (bus.reg_we) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected none", bus.reg_addr, bus.reg_wdata);
        end else begin
          check("wr_addr_data", {bus.reg_addr, bus.reg_wdata}, exp_wr.pop_front());
        end
        slave_mem[bus.reg_addr] = bus.reg_wdata;
      end
      if (bus.reg_re) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL re_unexpected: got addr %0h expected none", bus.reg_addr);
        end else begin
          check("re_addr", bus.reg_addr, exp_rd.pop_front());
        end
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) begin
          total++; bad++;
          $display("FAIL fd_unexpected: got pulse expected none");
        end else begin
          check("frame_done", 1, exp_fd.pop_front());
        end
      end
    end
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      if (exp_miso.size() == 0) begin
        total++; bad++;
        $display("FAIL miso_unexpected: got bit %0b expected none", spi_miso);
      end else begin
        check("miso_bit", spi_miso, exp_miso.pop_front());
      end
      check("miso_oe_active", miso_oe, 1);
    end
  end

  // Reference: what a frame of cmd_bits command bits and data_bits data bits must produce.
  task automatic model_frame(input logic [7:0] cmd, input int cmd_bits, input int data_bits, input bit ends);
    int a, nfull, ad;
    if (cmd_bits < 8) begin
      for (int i = 0; i < cmd_bits; i++) exp_miso.push_back(1'b0);
      return;
    end
    a = int'(cmd[6:0]);
    nfull = data_bits / 16;
    for (int i = 0; i < 8; i++) exp_miso.push_back(1'b0);
    if (!cmd[7]) begin
      for (int k = 0; k < nfull; k++) begin
        ad = (a + k * INC) % 128;
        exp_wr.push_back({7'(ad), words[k]});
        model_mem[ad] = words[k];
      end
      for (int i = 0; i < data_bits; i++) exp_miso.push_back(1'b0);
    end else begin
      for (int k = 0; k <= nfull; k++) exp_rd.push_back(7'((a + k * INC) % 128));
      for (int i = 0; i < data_bits; i++) begin
        ad = (a + (i / 16) * INC) % 128;
        exp_miso.push_back(model_mem[ad][15 - (i % 16)]);
      end
    end
    if (ends) exp_fd.push_back(1'b1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sck_in);
  endtask

  task automatic send_bit(input bit b);
    spi_mosi = b;
    wait_cyc(HALF);
    spi_sck = 1'b1;
    wait_cyc(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int cmd_bits, input int data_bits, input bit cs_with_last);
    bit b;
    model_frame(cmd, cmd_bits, cs_with_last ? data_bits - 1 : data_bits, 1'b1);
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < cmd_bits; i++) send_bit(cmd[7 - i]);
    for (int j = 0; j < data_bits; j++) begin
      b = words[j / 16][15 - (j % 16)];
      if (cs_with_last && j == data_bits - 1) begin
        spi_mosi = b;
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b1;
        wait_cyc(HALF);
        spi_sck  = 1'b0;
      end else begin
        send_bit(b);
      end
    end
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(4 * HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    bus.reg_we, 0);
    check({tag, "_re"},    bus.reg_re, 0);
    check({tag, "_fd"},    frame_done, 0);
    check({tag, "_miso"},  spi_miso, 0);
    check({tag, "_oe"},    miso_oe, 0);
    check({tag, "_addr"},  bus.reg_addr, 0);
    check({tag, "_wdata"}, bus.reg_wdata, 0);
  endtask

  initial begin
    repeat (90000) @(posedge sck_in);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    int nw, nb;
    logic [7:0] c;
    for (int i = 0; i < 128; i++) begin
      v = 16'($urandom);
      slave_mem[i] = v;
      model_mem[i] = v;
    end
    wait_cyc(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_cyc(10);

    words[0] = 16'hBEEF;
    frame(8'h05, 8, 16, 1'b0);

    slave_mem[5] = 16'h1234;
    model_mem[5] = 16'h1234;
    frame(8'h85, 8, 16, 1'b0);

    words[0] = 16'hBEEF; words[1] = 16'hCAFE;
    frame(8'h02, 8, 32, 1'b0);
    frame(8'h82, 8, 32, 1'b0);

    words[0] = 16'hA55A; words[1] = 16'h0F0F;
    frame(8'h7F, 8, 32, 1'b0);
    frame(8'hFF, 8, 32, 1'b0);

    words[0] = 16'h1357;
    frame(8'h01, 8, 10, 1'b0);
    check("oe_idle", miso_oe, 0);
    words[0] = 16'h2468;
    frame(8'h01, 8, 16, 1'b0);

    frame(8'h03, 5, 0, 1'b0);

    words[0] = 16'h9999;
    frame(8'h10, 8, 16, 1'b1);
    frame(8'h90, 8, 16, 1'b0);

    for (int r = 0; r < 10; r++) begin
      c  = 8'($urandom);
      nw = int'($urandom_range(1, 3));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nw * 16 - 1)) : nw * 16;
      for (int k = 0; k < 4; k++) words[k] = 16'($urandom);
      frame(c, 8, nb, 1'b0);
    end

    // Reset asserted in the middle of a read word, released with CS still low.
    model_frame(8'h83, 8, 6, 1'b0);
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 8; i++) send_bit(c[i % 8] ^ (i == 0 ? 1'b1 : 1'b0) ? 8'h83 >> (7 - i) & 1 : 8'h83 >> (7 - i) & 1);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(HALF);
    for (int i = 0; i < 6; i++) exp_miso.push_back(1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(4 * HALF);
    frame(8'h85, 8, 16, 1'b0);

    wait_cyc(20);
    check("wr_queue_drained",   exp_wr.size(), 0);
    check("re_queue_drained",   exp_rd.size(), 0);
    check("fd_queue_drained",   exp_fd.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
